// File: rtl/io_bus_pkg.sv
// -----------------------------------------------------------------------------
// io_bus_pkg
// Shared types and constants for the two-master I/O bus arbiter.
//   - FSM state encoding (IDLE / ISSUE / RESP)
//   - Device decode field position and values (addr[9:8])
//   - Address / data widths
//   - io_decode(): maps the 2-bit decode field to a device selector
// -----------------------------------------------------------------------------
package io_bus_pkg;

  localparam int IO_ADDR_W  = 30;
  localparam int IO_DATA_W  = 32;

  // Device select lives in word-address bits [9:8]; everything above is ignored.
  localparam int          IO_DEC_LSB = 8;
  localparam logic [1:0]  IO_DEC_LED = 2'b01;
  localparam logic [1:0]  IO_DEC_SW  = 2'b10;

  typedef enum logic [1:0] {
    IO_IDLE  = 2'b00,
    IO_ISSUE = 2'b01,
    IO_RESP  = 2'b10
  } io_state_e;

  typedef enum logic [1:0] {
    IO_DEV_NONE = 2'b00,
    IO_DEV_LED  = 2'b01,
    IO_DEV_SW   = 2'b10
  } io_dev_e;

  // Translate the decode field into a device; 00 and 11 are unmapped.
  function automatic io_dev_e io_decode(input logic [1:0] field);
    io_dev_e dev;
    case (field)
      IO_DEC_LED: dev = IO_DEV_LED;
      IO_DEC_SW:  dev = IO_DEV_SW;
      default:    dev = IO_DEV_NONE;
    endcase
    return dev;
  endfunction

endpackage

// File: rtl/io_arb2.sv
// -----------------------------------------------------------------------------
// io_arb2
// Two-requester selector, purely combinational.
// Configuration macro: IO_ARB_FAIR_RR_EN
//   defined     : round-robin, the master not granted last wins a tie
//   not defined : fixed priority, requester 0 always wins a tie
// Ports:
//   req0_i, req1_i : request lines
//   last_m1_i      : 1 when requester 1 was granted most recently
//   gnt_o[1:0]     : one-hot winner (bit 0 = requester 0), 0 when no request
// -----------------------------------------------------------------------------
module io_arb2 (
  input  logic       req0_i,
  input  logic       req1_i,
  input  logic       last_m1_i,
  output logic [1:0] gnt_o
);

`ifdef IO_ARB_FAIR_RR_EN
  // Round-robin pick: a tie goes to whoever did not win last time.
  always_comb begin
    gnt_o = 2'b00;
    if (req0_i && req1_i) begin
      if (last_m1_i) begin
        gnt_o = 2'b01;
      end else begin
        gnt_o = 2'b10;
      end
    end else if (req0_i) begin
      gnt_o = 2'b01;
    end else if (req1_i) begin
      gnt_o = 2'b10;
    end else begin
      gnt_o = 2'b00;
    end
  end
`else
  // Fixed priority has no use for the history pointer.
  logic last_unused_s;
  assign last_unused_s = last_m1_i;

  // Fixed-priority pick: requester 0 first.
  always_comb begin
    gnt_o = 2'b00;
    if (req0_i) begin
      gnt_o = 2'b01;
    end else if (req1_i) begin
      gnt_o = 2'b10;
    end else begin
      gnt_o = 2'b00;
    end
  end
`endif

endmodule

// File: rtl/io_bus_arbiter.sv
// -----------------------------------------------------------------------------
// io_bus_arbiter
// Grants one of two masters' single-word requests at a time, drives the shared
// I/O bus with per-device strobes and returns read data to the requester.
// Configuration macro: IO_ARB_FAIR_RR_EN (round-robin ties; otherwise m0 wins).
// Ports:
//   clk, rst                  : clock, asynchronous active-low reset
//   mX_req/we/addr/wdata      : master X request (held until mX_gnt)
//   mX_gnt                    : one-cycle grant pulse, request consumed
//   mX_rvalid/mX_rdata        : read return pulse / data (data held afterwards)
//   bus_memAddress/writeData  : shared bus, latched at grant
//   led_we, led_re, sw_re     : device strobes, high in the ISSUE cycle
//   led_rdata, sw_rdata       : peripheral read data, one cycle after re
//   decode_err                : pulse for a granted access to an unmapped addr
// Every output comes straight from a flop.
// -----------------------------------------------------------------------------
module io_bus_arbiter
  import io_bus_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 m0_req,
  input  logic                 m0_we,
  input  logic [IO_ADDR_W-1:0] m0_addr,
  input  logic [IO_DATA_W-1:0] m0_wdata,
  output logic                 m0_gnt,
  output logic                 m0_rvalid,
  output logic [IO_DATA_W-1:0] m0_rdata,
  input  logic                 m1_req,
  input  logic                 m1_we,
  input  logic [IO_ADDR_W-1:0] m1_addr,
  input  logic [IO_DATA_W-1:0] m1_wdata,
  output logic                 m1_gnt,
  output logic                 m1_rvalid,
  output logic [IO_DATA_W-1:0] m1_rdata,
  output logic [IO_ADDR_W-1:0] bus_memAddress,
  output logic [IO_DATA_W-1:0] bus_writeData,
  output logic                 led_we,
  output logic                 led_re,
  output logic                 sw_re,
  input  logic [IO_DATA_W-1:0] led_rdata,
  input  logic [IO_DATA_W-1:0] sw_rdata,
  output logic                 decode_err
);

  io_state_e              state_q, state_d;
  logic [1:0]             win_s;
  logic                   ptr_s;
  logic                   grant_s;
  logic                   sel_m1_s;
  logic                   sel_we_s;
  logic [IO_ADDR_W-1:0]   sel_addr_s;
  logic [IO_DATA_W-1:0]   sel_wdata_s;
  io_dev_e                sel_dev_s;
  logic [IO_DATA_W-1:0]   resp_data_s;

  logic                   win_m1_q;
  logic                   we_q;
  io_dev_e                dev_q;
  logic [IO_ADDR_W-1:0]   bus_addr_q;
  logic [IO_DATA_W-1:0]   bus_wdata_q;
  logic                   m0_gnt_q, m1_gnt_q;
  logic                   led_we_q, led_re_q, sw_re_q, decode_err_q;
  logic                   m0_rvalid_q, m1_rvalid_q;
  logic [IO_DATA_W-1:0]   m0_rdata_q, m1_rdata_q;

  io_arb2 u_arb (
    .req0_i    (m0_req),
    .req1_i    (m1_req),
    .last_m1_i (ptr_s),
    .gnt_o     (win_s)
  );

  // The arbiter's choice only counts while idle; later requests simply wait.
  assign grant_s  = (state_q == IO_IDLE) && (win_s != 2'b00);
  assign sel_m1_s = win_s[1];

  // Mux the winning master's request fields.
  always_comb begin
    if (sel_m1_s) begin
      sel_we_s    = m1_we;
      sel_addr_s  = m1_addr;
      sel_wdata_s = m1_wdata;
    end else begin
      sel_we_s    = m0_we;
      sel_addr_s  = m0_addr;
      sel_wdata_s = m0_wdata;
    end
  end

  assign sel_dev_s = io_decode(sel_addr_s[IO_DEC_LSB+1:IO_DEC_LSB]);

`ifdef IO_ARB_FAIR_RR_EN
  logic last_m1_q;

  // Remember the most recent winner; reset to m1 so m0 takes the first tie.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      last_m1_q <= 1'b1;
    end else if (grant_s) begin
      last_m1_q <= sel_m1_s;
    end else begin
      last_m1_q <= last_m1_q;
    end
  end

  assign ptr_s = last_m1_q;
`else
  assign ptr_s = 1'b1;
`endif

  // Next-state: reads spend one extra cycle in RESP to capture peripheral data.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IO_IDLE: begin
        if (grant_s) begin
          state_d = IO_ISSUE;
        end else begin
          state_d = IO_IDLE;
        end
      end
      IO_ISSUE: begin
        if (we_q) begin
          state_d = IO_IDLE;
        end else begin
          state_d = IO_RESP;
        end
      end
      IO_RESP: state_d = IO_IDLE;
      default: state_d = IO_IDLE;
    endcase
  end

  // State register and the request fields latched at grant time.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IO_IDLE;
      win_m1_q    <= 1'b0;
      we_q        <= 1'b0;
      dev_q       <= IO_DEV_NONE;
      bus_addr_q  <= '0;
      bus_wdata_q <= '0;
    end else begin
      state_q <= state_d;
      if (grant_s) begin
        win_m1_q    <= sel_m1_s;
        we_q        <= sel_we_s;
        dev_q       <= sel_dev_s;
        bus_addr_q  <= sel_addr_s;
        bus_wdata_q <= sel_wdata_s;
      end else begin
        win_m1_q    <= win_m1_q;
        we_q        <= we_q;
        dev_q       <= dev_q;
        bus_addr_q  <= bus_addr_q;
        bus_wdata_q <= bus_wdata_q;
      end
    end
  end

  // Grant and strobe pulses are produced one edge early so they line up with
  // the ISSUE cycle; switch writes deliberately raise nothing.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      m0_gnt_q     <= 1'b0;
      m1_gnt_q     <= 1'b0;
      led_we_q     <= 1'b0;
      led_re_q     <= 1'b0;
      sw_re_q      <= 1'b0;
      decode_err_q <= 1'b0;
    end else begin
      m0_gnt_q     <= grant_s && !sel_m1_s;
      m1_gnt_q     <= grant_s && sel_m1_s;
      led_we_q     <= grant_s && sel_we_s && (sel_dev_s == IO_DEV_LED);
      led_re_q     <= grant_s && !sel_we_s && (sel_dev_s == IO_DEV_LED);
      sw_re_q      <= grant_s && !sel_we_s && (sel_dev_s == IO_DEV_SW);
      decode_err_q <= grant_s && (sel_dev_s == IO_DEV_NONE);
    end
  end

  // Pick the responding peripheral's data; unmapped reads return zero.
  always_comb begin
    resp_data_s = 32'h0000_0000;
    case (dev_q)
      IO_DEV_LED: resp_data_s = led_rdata;
      IO_DEV_SW:  resp_data_s = sw_rdata;
      default:    resp_data_s = 32'h0000_0000;
    endcase
  end

  // Capture read data in RESP and flag it to the winner on the following cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      m0_rvalid_q <= 1'b0;
      m1_rvalid_q <= 1'b0;
      m0_rdata_q  <= '0;
      m1_rdata_q  <= '0;
    end else if (state_q == IO_RESP) begin
      m0_rvalid_q <= !win_m1_q;
      m1_rvalid_q <= win_m1_q;
      if (win_m1_q) begin
        m1_rdata_q <= resp_data_s;
        m0_rdata_q <= m0_rdata_q;
      end else begin
        m0_rdata_q <= resp_data_s;
        m1_rdata_q <= m1_rdata_q;
      end
    end else begin
      m0_rvalid_q <= 1'b0;
      m1_rvalid_q <= 1'b0;
      m0_rdata_q  <= m0_rdata_q;
      m1_rdata_q  <= m1_rdata_q;
    end
  end

  assign m0_gnt         = m0_gnt_q;
  assign m1_gnt         = m1_gnt_q;
  assign m0_rvalid      = m0_rvalid_q;
  assign m1_rvalid      = m1_rvalid_q;
  assign m0_rdata       = m0_rdata_q;
  assign m1_rdata       = m1_rdata_q;
  assign bus_memAddress = bus_addr_q;
  assign bus_writeData  = bus_wdata_q;
  assign led_we         = led_we_q;
  assign led_re         = led_re_q;
  assign sw_re          = sw_re_q;
  assign decode_err     = decode_err_q;

endmodule

// File: tb/tb_io_bus_arbiter.sv
// -----------------------------------------------------------------------------
// tb_io_bus_arbiter
// Self-checking bench: a transaction-level schedule model (who wins, when the
// bus is free again, when a read returns) is compared with every DUT output on
// every cycle, plus literal expectations for the directed scenarios.
// -----------------------------------------------------------------------------
module tb_io_bus_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_a   [2];
  logic        we_a    [2];
  logic [29:0] addr_a  [2];
  logic [31:0] wdata_a [2];
  logic [31:0] led_rdata, sw_rdata;

  logic        m0_gnt, m1_gnt, m0_rvalid, m1_rvalid;
  logic [31:0] m0_rdata, m1_rdata;
  logic [29:0] bus_memAddress;
  logic [31:0] bus_writeData;
  logic        led_we, led_re, sw_re, decode_err;

  int total = 0;
  int bad   = 0;

  // model state
  int          tnow   = 0;
  int          free_t = 0;
  bit          pend   = 1'b0;
  int          pend_at, pend_w;
  logic [1:0]  pend_dev;
  bit          last   = 1'b1;
  logic [1:0]  e_gnt, e_rv;
  logic        e_led_we, e_led_re, e_sw_re, e_err;
  logic [29:0] e_addr;
  logic [31:0] e_wdata;
  logic [31:0] e_rdata [2];

  always #5 clk = ~clk;

  io_bus_arbiter dut (
    .clk            (clk),
    .rst            (rst),
    .m0_req         (req_a[0]),
    .m0_we          (we_a[0]),
    .m0_addr        (addr_a[0]),
    .m0_wdata       (wdata_a[0]),
    .m0_gnt         (m0_gnt),
    .m0_rvalid      (m0_rvalid),
    .m0_rdata       (m0_rdata),
    .m1_req         (req_a[1]),
    .m1_we          (we_a[1]),
    .m1_addr        (addr_a[1]),
    .m1_wdata       (wdata_a[1]),
    .m1_gnt         (m1_gnt),
    .m1_rvalid      (m1_rvalid),
    .m1_rdata       (m1_rdata),
    .bus_memAddress (bus_memAddress),
    .bus_writeData  (bus_writeData),
    .led_we         (led_we),
    .led_re         (led_re),
    .sw_re          (sw_re),
    .led_rdata      (led_rdata),
    .sw_rdata       (sw_rdata),
    .decode_err     (decode_err)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %08h, want %08h (t=%0d)", name, act, exp, tnow);
    end
  endtask

  // Advance the model by one clock edge using the inputs the DUT sampled.
  task automatic step();
    int         w;
    logic [1:0] dev;
    e_gnt = 2'b00; e_rv = 2'b00;
    e_led_we = 1'b0; e_led_re = 1'b0; e_sw_re = 1'b0; e_err = 1'b0;
    tnow++;
    if (!rst) begin
      free_t = 0; pend = 1'b0; last = 1'b1;
      e_addr = '0; e_wdata = '0; e_rdata[0] = '0; e_rdata[1] = '0;
    end else begin
      if (pend && tnow == pend_at) begin
        if (pend_dev == 2'b01)      e_rdata[pend_w] = led_rdata;
        else if (pend_dev == 2'b10) e_rdata[pend_w] = sw_rdata;
        else                        e_rdata[pend_w] = 32'h0;
        e_rv[pend_w] = 1'b1;
        pend = 1'b0;
      end
      if (tnow >= free_t && (req_a[0] || req_a[1])) begin
`ifdef IO_ARB_FAIR_RR_EN
        if (req_a[0] && req_a[1]) w = last ? 0 : 1;
        else                      w = req_a[0] ? 0 : 1;
`else
        w = req_a[0] ? 0 : 1;
`endif
        last     = (w == 1);
        e_gnt[w] = 1'b1;
        e_addr   = addr_a[w];
        e_wdata  = wdata_a[w];
        dev      = addr_a[w][9:8];
        if (we_a[w]) begin
          if (dev == 2'b01)      e_led_we = 1'b1;
          else if (dev != 2'b10) e_err    = 1'b1;
          free_t = tnow + 2;
        end else begin
          if (dev == 2'b01)      e_led_re = 1'b1;
          else if (dev == 2'b10) e_sw_re  = 1'b1;
          else                   e_err    = 1'b1;
          pend = 1'b1; pend_at = tnow + 2; pend_w = w; pend_dev = dev;
          free_t = tnow + 3;
        end
      end
    end
  endtask

  task automatic compare_all();
    chk("m0_gnt",     32'(m0_gnt),         32'(e_gnt[0]));
    chk("m1_gnt",     32'(m1_gnt),         32'(e_gnt[1]));
    chk("m0_rvalid",  32'(m0_rvalid),      32'(e_rv[0]));
    chk("m1_rvalid",  32'(m1_rvalid),      32'(e_rv[1]));
    chk("m0_rdata",   m0_rdata,            e_rdata[0]);
    chk("m1_rdata",   m1_rdata,            e_rdata[1]);
    chk("bus_addr",   32'(bus_memAddress), 32'(e_addr));
    chk("bus_wdata",  bus_writeData,       e_wdata);
    chk("led_we",     32'(led_we),         32'(e_led_we));
    chk("led_re",     32'(led_re),         32'(e_led_re));
    chk("sw_re",      32'(sw_re),          32'(e_sw_re));
    chk("decode_err", 32'(decode_err),     32'(e_err));
  endtask

  task automatic cycle();
    @(posedge clk);
    step();
    @(negedge clk);
    compare_all();
  endtask

  task automatic set_req(input int i, input logic we, input logic [29:0] a, input logic [31:0] d);
    req_a[i] = 1'b1; we_a[i] = we; addr_a[i] = a; wdata_a[i] = d;
  endtask

  task automatic new_random_req(input int i);
    logic [29:0] a;
    a = 30'($urandom);
    a[9:8] = 2'($urandom_range(0, 3));
    set_req(i, 1'($urandom_range(0, 1)), a, $urandom);
  endtask

  int seq [$];
  int exp_seq [4];

  initial begin
    rst = 1'b0;
    for (int i = 0; i < 2; i++) begin
      req_a[i] = 1'b0; we_a[i] = 1'b0; addr_a[i] = '0; wdata_a[i] = '0;
    end
    led_rdata = 32'h0; sw_rdata = 32'h0;

    // reset state
    repeat (3) cycle();
    chk("reset_bus_addr", 32'(bus_memAddress), 32'h0);
    rst = 1'b1;

    // contention: both masters keep requesting reads
`ifdef IO_ARB_FAIR_RR_EN
    exp_seq = '{0, 1, 0, 1};
`else
    exp_seq = '{0, 0, 0, 0};
`endif
    set_req(0, 1'b0, 30'h100, 32'h0);
    set_req(1, 1'b0, 30'h200, 32'h0);
    for (int k = 0; k < 13; k++) begin
      cycle();
      if (m0_gnt) seq.push_back(0);
      if (m1_gnt) seq.push_back(1);
    end
    chk("cont_grants", 32'(seq.size() >= 4), 32'h1);
    for (int k = 0; k < 4; k++)
      if (k < seq.size()) chk("cont_order", 32'(seq[k]), 32'(exp_seq[k]));
    req_a[0] = 1'b0; req_a[1] = 1'b0;
    repeat (4) cycle();

    // single LED write
    set_req(0, 1'b1, 30'h100, 32'h0000A5A5);
    cycle();
    chk("wr_gnt", 32'(m0_gnt), 32'h1);
    chk("wr_led_we", 32'(led_we), 32'h1);
    chk("wr_wdata", bus_writeData, 32'h0000A5A5);
    req_a[0] = 1'b0;
    cycle();
    chk("wr_led_we_off", 32'(led_we), 32'h0);
    cycle();
    chk("wr_no_rvalid", 32'(m0_rvalid), 32'h0);

    // single switch read from m1
    sw_rdata = 32'h00001234;
    set_req(1, 1'b0, 30'h200, 32'h0);
    cycle();
    chk("rd_gnt", 32'(m1_gnt), 32'h1);
    chk("rd_sw_re", 32'(sw_re), 32'h1);
    req_a[1] = 1'b0;
    cycle();
    chk("rd_sw_re_off", 32'(sw_re), 32'h0);
    cycle();
    chk("rd_rvalid", 32'(m1_rvalid), 32'h1);
    chk("rd_rdata", m1_rdata, 32'h00001234);
    cycle();
    chk("rd_rvalid_off", 32'(m1_rvalid), 32'h0);
    chk("rd_rdata_held", m1_rdata, 32'h00001234);

    // unmapped read from m0
    set_req(0, 1'b0, 30'h000, 32'h0);
    cycle();
    chk("um_err", 32'(decode_err), 32'h1);
    chk("um_strobes", 32'({led_we, led_re, sw_re}), 32'h0);
    req_a[0] = 1'b0;
    cycle();
    cycle();
    chk("um_rvalid", 32'(m0_rvalid), 32'h1);
    chk("um_rdata", m0_rdata, 32'h0);
    cycle();

    // reset while a read sits in RESP
    led_rdata = 32'hCAFE0001;
    set_req(0, 1'b0, 30'h100, 32'h0);
    cycle();
    req_a[0] = 1'b0;
    cycle();
    rst = 1'b0;
    cycle();
    chk("rstr_rvalid", 32'(m0_rvalid), 32'h0);
    chk("rstr_m1_rdata", m1_rdata, 32'h0);
    chk("rstr_bus_addr", 32'(bus_memAddress), 32'h0);
    cycle();
    rst = 1'b1;
    set_req(0, 1'b0, 30'h100, 32'h0);
    cycle();
    chk("rstr_next_gnt", 32'(m0_gnt), 32'h1);
    chk("rstr_next_led_re", 32'(led_re), 32'h1);
    req_a[0] = 1'b0;
    cycle();
    cycle();
    chk("rstr_next_rvalid", 32'(m0_rvalid), 32'h1);
    chk("rstr_next_rdata", m0_rdata, 32'hCAFE0001);
    cycle();

    // randomized traffic with occasional resets
    for (int k = 0; k < 2000; k++) begin
      for (int i = 0; i < 2; i++) begin
        if (req_a[i] && e_gnt[i]) begin
          if ($urandom_range(0, 3) == 0) new_random_req(i);
          else req_a[i] = 1'b0;
        end else if (!req_a[i] && $urandom_range(0, 2) == 0) begin
          new_random_req(i);
        end
      end
      led_rdata = $urandom;
      sw_rdata  = $urandom;
      if (!rst) rst = 1'b1;
      else if ($urandom_range(0, 399) == 0) rst = 1'b0;
      cycle();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL timeout: bench did not finish (t=%0d)", tnow);
    $fatal(1, "timeout");
  end

endmodule

// File: doc/io_bus_arbiter.md
# io_bus_arbiter

Two-master arbiter and sequencer for the shared memory-mapped I/O bus that drives the LED and switch peripherals. A front-end FSM or counter and a processor-side port each issue single-word read and write requests. The block grants one request at a time and drives the shared bus with per-device strobes from an address decode. Read data is returned to the requesting master with a valid pulse. It sits between the requesters and the `leds`/`switches` interface modules in the system top.

## Interface
- No parameters. Widths are fixed: address 30 bits (word address), data 32 bits.
- `clk` in 1: system clock, 100 MHz.
- `rst` in 1: asynchronous, active-low reset.
- `m0_req`, `m1_req` in 1: request. Hold high, with the other fields stable, until the matching `gnt`.
- `m0_we`, `m1_we` in 1: 1 = write, 0 = read.
- `m0_addr`, `m1_addr` in 30: word address.
- `m0_wdata`, `m1_wdata` in 32: write data.
- `m0_gnt`, `m1_gnt` out 1: one-cycle grant pulse. The request is consumed.
- `m0_rvalid`, `m1_rvalid` out 1: one-cycle read-return pulse.
- `m0_rdata`, `m1_rdata` out 32: read data, valid while `rvalid` is high, held afterwards.
- `bus_memAddress` out 30, `bus_writeData` out 32: shared bus.
- `led_we`, `led_re`, `sw_re` out 1: device strobes.
- `led_rdata`, `sw_rdata` in 32: peripheral read data, registered by the peripheral, valid one cycle after `re`.
- `decode_err` out 1: one-cycle pulse when a granted access hits an unmapped address.

## Operation
- FSM states:
  - IDLE → ISSUE when any request is present and selected; the chosen request's fields are latched.
  - ISSUE → RESP when the access is a read.
  - ISSUE → IDLE when the access is a write.
  - RESP → IDLE unconditionally.
- Address decode on `addr[9:8]`:
  - 01 = LED.
  - 10 = switches.
  - 00 and 11 = unmapped.
  - Higher address bits are ignored.
- ISSUE cycle:
  - The winner's `gnt` is high.
  - `bus_memAddress`/`bus_writeData` carry the latched values.
  - Exactly one strobe is high for a mapped access.
  - Writes to switches are dropped silently: no strobe and no error.
  - For unmapped accesses, no strobe is driven and `decode_err` pulses.
- RESP cycle: the selected `*_rdata` is registered into the winner's `rdata` (0 for unmapped), and the winner's `rvalid` is set for the next cycle.
- Arbitration is evaluated only in IDLE. Requests arriving during ISSUE or RESP wait.
- Reset values:
  - State IDLE.
  - All `gnt`, `rvalid`, strobes and `decode_err` are 0.
  - `rdata`, `bus_memAddress` and `bus_writeData` are 0.
  - Last-grant pointer = m1, so m0 wins the first tie.
- Reset asserted mid-transaction aborts it: no `gnt`, `rvalid` or strobe follows; the state is IDLE after release.
- A master that keeps `req` high after its `gnt` makes a new request.

## Timing
- `req` sampled at edge N in IDLE:
  - `gnt` and strobes are high in cycle N+1.
  - Read: peripheral data arrives in N+2, and `rvalid`/`rdata` are high in N+3.
- Throughput:
  - Writes: one per 2 cycles.
  - Reads: one per 3 cycles (the IDLE cycle coincides with `rvalid`).
- All outputs are registered or decoded from registered state only. There are no combinational paths from `req` to `gnt`.

## Configuration
- `IO_ARB_FAIR_RR_EN` defined: round-robin. On simultaneous requests, the master not granted last wins. The pointer updates on every grant.
- `IO_ARB_FAIR_RR_EN` not defined: fixed priority, m0 always wins ties. The pointer logic is absent.

## Structure
- Package `io_bus_pkg` holds:
  - The state enum (IDLE, ISSUE, RESP).
  - The decode field constants: `IO_DEC_LSB`=8, `IO_DEC_LED`=2'b01, `IO_DEC_SW`=2'b10.
  - The width constants 30/32.
- Sub-module `io_arb2`: a two-requester selector. Inputs are the requests and the last-grant pointer; outputs are the one-hot winner. It contains the `IO_ARB_FAIR_RR_EN` logic.

## Test plan
- Single write: m0 write, addr 0x100, data 0x0000A5A5.
  - Required: `m0_gnt` and `led_we` high one cycle in N+1, `bus_writeData` = 0x0000A5A5, no `rvalid`.
- Single read: m1 reads addr 0x200, `sw_rdata` = 0x00001234.
  - Required: `m1_rvalid` high in N+3 with `m1_rdata` = 0x00001234, `sw_re` high only in N+1.
- Contention, round-robin: m0 and m1 both request reads continuously with `IO_ARB_FAIR_RR_EN` defined.
  - Required: grants alternate m0, m1, m0, m1.
- Contention, fixed priority: same stimulus without the macro.
  - Required: m0 granted every time, m1 starves.
- Unmapped read: m0 reads addr 0x000.
  - Required: `decode_err` pulses in N+1, no strobes, `m0_rvalid` in N+3 with `m0_rdata` = 0.
- Reset during RESP: drop `rst` during RESP of a read.
  - Required: no `rvalid`, all outputs 0, the next request after release completes normally.
